data_unloader: RTL



---
 rtl/data_unloader_pkg.sv | 22 ++
 rtl/unloader_word_fetch.sv | 88 ++++++++
 rtl/data_unloader.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/data_unloader_pkg.sv
// Shared types and helpers for the APF bridge read-back path (data_unloader).
// Holds the fetch FSM states, the fetch kind and the bridge endian swap.
package data_unloader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } fetch_state_t;

   typedef enum logic {
      KIND_DEMAND   = 1'b0,
      KIND_PREFETCH = 1'b1
   } fetch_kind_t;

   // The bridge wants big-endian words unless the host asked for little.
   function automatic logic [31:0] endian_swap(input logic [31:0] a, input logic little);
      return little ? a : {a[7:0], a[15:8], a[23:16], a[31:24]};
   endfunction

endpackage

// File: rtl/unloader_word_fetch.sv
// Fetches one 32-bit word as 4/MEM_WORD_SIZE narrow memory reads and assembles it.
// A new start is accepted in IDLE or in DONE, so back-to-back fetches keep busy high.
module unloader_word_fetch
   import data_unloader_pkg::*;
#(
   parameter int ADDRESS_SIZE         = 14,
   parameter int READ_MEM_CLOCK_DELAY = 4,
   parameter int MEM_WORD_SIZE        = 1
) (
   input  logic                       clk_74a,
   input  logic                       reset,
   input  logic                       start,
   input  logic [ADDRESS_SIZE:0]      base,
   input  logic [8*MEM_WORD_SIZE-1:0] read_data,
   output logic                       read_en,
   output logic [ADDRESS_SIZE:0]      read_addr,
   output logic                       busy,
   output logic                       done,
   output logic [31:0]                word,
   output logic [1:0]                 state_dbg
);

   localparam int AW = ADDRESS_SIZE + 1;
   localparam int N  = 4 / MEM_WORD_SIZE;
   localparam int W  = 8 * MEM_WORD_SIZE;
   localparam logic [1:0] K_LAST   = 2'(N - 1);
   localparam logic [7:0] CNT_INIT = 8'(READ_MEM_CLOCK_DELAY - 1);

   fetch_state_t state, state_nxt;
   logic [1:0]   k;
   logic [7:0]   cnt;
   logic [31:0]  asm_q;
   logic         accept;

   assign accept    = start && (state == IDLE || state == DONE);
   assign read_en   = (state == ISSUE);
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign word      = asm_q;
   assign state_dbg = state;

   always_ff @(posedge clk_74a or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (cnt == 8'd0) state_nxt = (k == K_LAST) ? DONE : ISSUE;
         DONE:    state_nxt = start ? ISSUE : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // read_addr holds the current sub-read address; it advances as each slot lands.
   always_ff @(posedge clk_74a or posedge reset) begin
      if (reset) begin
         k         <= 2'd0;
         cnt       <= 8'd0;
         asm_q     <= 32'd0;
         read_addr <= '0;
      end else if (accept) begin
         k         <= 2'd0;
         asm_q     <= 32'd0;
         read_addr <= base;
      end else begin
         case (state)
            ISSUE: cnt <= CNT_INIT;
            WAIT: begin
               if (cnt == 8'd0) begin
                  asm_q[int'(k)*W +: W] <= read_data;
                  if (k != K_LAST) begin
                     k         <= k + 2'd1;
                     read_addr <= read_addr + AW'(MEM_WORD_SIZE);
                  end
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/data_unloader.sv
// APF bridge read server: demand fetch, sequential prefetch and one pending request.
// Word assembly lives in unloader_word_fetch; this level decides what to fetch next.
module data_unloader
   import data_unloader_pkg::*;
#(
   parameter int ADDRESS_MASK_UPPER_4 = 0,
   parameter int ADDRESS_SIZE         = 14,
   parameter int READ_MEM_CLOCK_DELAY = 4,
   parameter int MEM_WORD_SIZE        = 1,
   parameter int PREFETCH             = 1
) (
   input  logic                       clk_74a,
   input  logic                       reset,
   input  logic                       bridge_rd,
   input  logic                       bridge_endian_little,
   input  logic [31:0]                bridge_addr,
   output logic [31:0]                bridge_rd_data,
   output logic                       rd_busy,
   output logic                       read_en,
   output logic [ADDRESS_SIZE:0]      read_addr,
   input  logic [8*MEM_WORD_SIZE-1:0] read_data
);

   localparam int AW = ADDRESS_SIZE + 1;

   logic              hit;
   logic [AW-1:0]     hit_addr;
   logic              f_busy, f_done;
   logic [31:0]       f_word;
   logic [1:0]        f_state;
   logic              unused_bits;

   fetch_kind_t       cur_kind;
   logic [AW-1:0]     cur_addr;
   logic              cur_little;
   logic              pf_valid;
   logic [AW-1:0]     pf_addr;
   logic [31:0]       pf_word;
   logic              pend;
   logic [AW-1:0]     pend_addr;
   logic              pend_little;

   logic              start;
   fetch_kind_t       start_kind;
   logic [AW-1:0]     start_base;
   logic              start_little;
   logic              serve;
   logic [31:0]       serve_word;
   logic              serve_little;
   logic              pf_store;
   logic              eff_pend;
   logic [AW-1:0]     eff_addr;
   logic              eff_little;

   assign hit         = bridge_rd && (bridge_addr[31:28] == 4'(ADDRESS_MASK_UPPER_4));
   assign hit_addr    = {bridge_addr[ADDRESS_SIZE:2], 2'b00};
   assign rd_busy     = f_busy;
   assign unused_bits = ^{bridge_addr[27:ADDRESS_SIZE+1], bridge_addr[1:0], f_state};

   // A hit landing on the DONE cycle itself is treated like an already-latched pend.
   assign eff_pend   = pend || hit;
   assign eff_addr   = hit ? hit_addr : pend_addr;
   assign eff_little = hit ? bridge_endian_little : pend_little;

   always_comb begin
      start        = 1'b0;
      start_kind   = KIND_DEMAND;
      start_base   = '0;
      start_little = 1'b0;
      serve        = 1'b0;
      serve_word   = 32'd0;
      serve_little = 1'b0;
      pf_store     = 1'b0;
      if (!f_busy) begin
         if (hit) begin
            start = 1'b1;
            if (PREFETCH != 0 && pf_valid && hit_addr == pf_addr) begin
               serve        = 1'b1;
               serve_word   = pf_word;
               serve_little = bridge_endian_little;
               start_kind   = KIND_PREFETCH;
               start_base   = hit_addr + AW'(4);
            end else begin
               start_base   = hit_addr;
               start_little = bridge_endian_little;
            end
         end
      end else if (f_done) begin
         if (cur_kind == KIND_DEMAND) begin
            serve        = 1'b1;
            serve_word   = f_word;
            serve_little = cur_little;
            if (eff_pend) begin
               start        = 1'b1;
               start_base   = eff_addr;
               start_little = eff_little;
            end else if (PREFETCH != 0) begin
               start      = 1'b1;
               start_kind = KIND_PREFETCH;
               start_base = cur_addr + AW'(4);
            end
         end else if (eff_pend && eff_addr == cur_addr) begin
            // The host caught up with the prefetch: hand it over and run ahead again.
            serve        = 1'b1;
            serve_word   = f_word;
            serve_little = eff_little;
            start        = 1'b1;
            start_kind   = KIND_PREFETCH;
            start_base   = cur_addr + AW'(4);
         end else begin
            pf_store = 1'b1;
            if (eff_pend) begin
               start        = 1'b1;
               start_base   = eff_addr;
               start_little = eff_little;
            end
         end
      end
   end

   always_ff @(posedge clk_74a or posedge reset) begin
      if (reset) begin
         bridge_rd_data <= 32'd0;
         cur_kind       <= KIND_DEMAND;
         cur_addr       <= '0;
         cur_little     <= 1'b0;
         pf_valid       <= 1'b0;
         pf_addr        <= '0;
         pf_word        <= 32'd0;
         pend           <= 1'b0;
         pend_addr      <= '0;
         pend_little    <= 1'b0;
      end else begin
         if (serve) bridge_rd_data <= endian_swap(serve_word, serve_little);
         if (pf_store) begin
            pf_word  <= f_word;
            pf_valid <= 1'b1;
         end
         if (start) begin
            cur_kind   <= start_kind;
            cur_addr   <= start_base;
            cur_little <= start_little;
            if (start_kind == KIND_PREFETCH) begin
               pf_addr  <= start_base;
               pf_valid <= 1'b0;
            end
         end
         if (f_done) begin
            pend <= 1'b0;
         end else if (hit && f_busy) begin
            pend        <= 1'b1;
            pend_addr   <= hit_addr;
            pend_little <= bridge_endian_little;
         end
      end
   end

   unloader_word_fetch #(
      .ADDRESS_SIZE        (ADDRESS_SIZE),
      .READ_MEM_CLOCK_DELAY(READ_MEM_CLOCK_DELAY),
      .MEM_WORD_SIZE       (MEM_WORD_SIZE)
   ) u_fetch (
      .clk_74a  (clk_74a),
      .reset    (reset),
      .start    (start),
      .base     (start_base),
      .read_data(read_data),
      .read_en  (read_en),
      .read_addr(read_addr),
      .busy     (f_busy),
      .done     (f_done),
      .word     (f_word),
      .state_dbg(f_state)
   );

endmodule
